// File: rtl/answer_seg7_scan.sv
// Multiplexed 8-digit hex display driver for the 32-bit CPU answer.
// The shown value is reloaded only at frame boundaries, so a frame never tears.
module answer_seg7_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int LZ_BLANK   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] answer,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]       ALL_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Decoder works in the active-low domain; polarity is applied once at the output.
    function automatic logic [7:0] hexdec(input logic [3:0] v);
        logic [7:0] s;
        s = 8'hFF;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] div_cnt_reg;
    logic [2:0]       dig_idx_reg;
    logic [31:0]      disp_val_reg;
    logic [7:0]       an_reg;
    logic [7:0]       seg_reg;
    logic             frame_done_reg;

    logic             tick;
    logic             reload;
    logic [7:0]       an_next;
    logic [7:0]       seg_next;
    logic [7:0]       digit_seg   [8];
    logic [7:0]       digit_blank;

    assign tick   = (div_cnt_reg == CNT_LAST);
    assign reload = tick && (dig_idx_reg == 3'd7);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_seg[gi] = hexdec(disp_val_reg[4*gi +: 4]);
            if (gi == 0) begin : g_first
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                // Blank when this digit and everything above it is zero.
                assign digit_blank[gi] = (LZ_BLANK != 0) && (disp_val_reg[31:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        an_next  = 8'b1 << dig_idx_reg;
        seg_next = digit_blank[dig_idx_reg] ? 8'hFF : digit_seg[dig_idx_reg];
        if (ACTIVE_LOW != 0) begin
            an_next = ~an_next;
        end else begin
            seg_next = ~seg_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg    <= '0;
            dig_idx_reg    <= 3'd0;
            disp_val_reg   <= 32'd0;
            frame_done_reg <= 1'b0;
            an_reg         <= ALL_OFF;
            seg_reg        <= ALL_OFF;
        end else begin
            if (tick) begin
                div_cnt_reg <= '0;
                dig_idx_reg <= dig_idx_reg + 3'd1;
            end else begin
                div_cnt_reg <= div_cnt_reg + CNT_W'(1);
            end
            frame_done_reg <= reload;
            if (reload && !freeze) begin
                disp_val_reg <= answer;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_answer_seg7_scan.sv
// Randomized bench: three display configurations share one stimulus stream and are
// compared every cycle against a cycle-count based model of the scan.
module tb_answer_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] answer;
    logic        freeze;

    logic [7:0] an_o  [3];
    logic [7:0] seg_o [3];
    logic       fd_o  [3];

    always #5 clk = ~clk;

    answer_seg7_scan #(.SCAN_DIV(2), .LZ_BLANK(0), .ACTIVE_LOW(1)) u_dflt (
        .clk(clk), .rst(rst), .answer(answer), .freeze(freeze),
        .an(an_o[0]), .seg(seg_o[0]), .frame_done(fd_o[0]));
    answer_seg7_scan #(.SCAN_DIV(2), .LZ_BLANK(1), .ACTIVE_LOW(1)) u_lz (
        .clk(clk), .rst(rst), .answer(answer), .freeze(freeze),
        .an(an_o[1]), .seg(seg_o[1]), .frame_done(fd_o[1]));
    answer_seg7_scan #(.SCAN_DIV(1), .LZ_BLANK(0), .ACTIVE_LOW(0)) u_fast (
        .clk(clk), .rst(rst), .answer(answer), .freeze(freeze),
        .an(an_o[2]), .seg(seg_o[2]), .frame_done(fd_o[2]));

    int checks = 0;
    int errors = 0;

    int         m_sd [3] = '{2, 2, 1};
    bit         m_lz [3] = '{1'b0, 1'b1, 1'b0};
    bit         m_al [3] = '{1'b1, 1'b1, 1'b0};
    int         m_n  [3];
    logic [31:0] m_disp [3];
    logic [7:0]  e_an  [3];
    logic [7:0]  e_seg [3];
    logic        e_fd  [3];
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: n edges since reset; slot = n/SCAN_DIV, digit = slot%8, reload every 8*SCAN_DIV edges.
    task automatic model_edge(input int k, input logic r, input logic [31:0] a, input logic f);
        int         d;
        logic [31:0] upper;
        logic [7:0]  s;
        logic [7:0]  oh;
        if (r) begin
            m_n[k]    = 0;
            m_disp[k] = 32'd0;
            e_an[k]   = m_al[k] ? 8'hFF : 8'h00;
            e_seg[k]  = m_al[k] ? 8'hFF : 8'h00;
            e_fd[k]   = 1'b0;
        end else begin
            d     = (m_n[k] / m_sd[k]) % 8;
            upper = m_disp[k] >> (4 * d);
            s     = (m_lz[k] && d > 0 && upper == 32'd0) ? 8'hFF : hex_tab[upper[3:0]];
            oh    = 8'd1 << d;
            e_an[k]  = m_al[k] ? ~oh : oh;
            e_seg[k] = m_al[k] ? s : ~s;
            m_n[k]   = m_n[k] + 1;
            e_fd[k]  = (m_n[k] % (8 * m_sd[k])) == 0;
            if (e_fd[k] && !f) m_disp[k] = a;
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] a, input logic f);
        @(negedge clk);
        rst    = r;
        answer = a;
        freeze = f;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k, r, a, f);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("an[%0d] n=%0d", k, m_n[k]), {24'd0, an_o[k]}, {24'd0, e_an[k]});
            check($sformatf("seg[%0d] n=%0d", k, m_n[k]), {24'd0, seg_o[k]}, {24'd0, e_seg[k]});
            check($sformatf("frame_done[%0d] n=%0d", k, m_n[k]), {31'd0, fd_o[k]}, {31'd0, e_fd[k]});
        end
    endtask

    function automatic logic [31:0] rand_answer();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(4, 31);
            2: v = 32'd0;
            default: v = {$urandom_range(0, 15), 28'd0} | 32'h8;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] a;
        logic        f;
        int          rst_left;
        rst = 1'b1; answer = 32'd0; freeze = 1'b0;

        // Reset, then the scan-order and freeze scenarios.
        repeat (3) cycle(1'b1, 32'd0, 1'b0);
        repeat (32) cycle(1'b0, 32'h0123_4567, 1'b0);
        repeat (16) cycle(1'b0, 32'hDEAD_BEEF, 1'b0);
        repeat (48) cycle(1'b0, 32'h0000_0001, 1'b1);
        repeat (32) cycle(1'b0, 32'h0000_0001, 1'b0);
        repeat (32) cycle(1'b0, 32'h0000_00A0, 1'b0);
        repeat (32) cycle(1'b0, 32'h0000_0000, 1'b0);
        // Mid-frame reset.
        repeat (5) cycle(1'b0, 32'h8888_8888, 1'b0);
        cycle(1'b1, 32'h8888_8888, 1'b0);
        repeat (20) cycle(1'b0, 32'h8888_8888, 1'b0);

        a = rand_answer();
        f = 1'b0;
        rst_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) a = rand_answer();
            if ($urandom_range(0, 39) == 0) f = ~f;
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            cycle(rst_left > 0, a, f);
            if (rst_left > 0) rst_left--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
